multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control sequencer for the multi-cycle RV32 core. It steps each instruction through fetch, decode, execute, memory and writeback over several clocks and drives every datapath strobe. Those strobes are the PC, instruction register, register-file write, data-memory request, writeback mux and next-PC mux. It handshakes with instruction and data memory, counts retired instructions, and halts on ECALL/EBREAK or an illegal opcode.

## Interface
Parameters:
- INSTRET_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- opcode  in  7  inst[6:0] from instruction register
- branch_taken  in  1  ALU compare result, valid in EXEC
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  fetch request, held until imem_ready
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  2  next PC: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR)
- alu_src  out  1  0 = rs2, 1 = imm
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4
- dmem_req  out  1  data access request, held until dmem_ready
- dmem_we  out  1  1 = store, qualifies dmem_req
- state  out  3  current state, for debug
- instret  out  INSTRET_W  retired-instruction count
- halted  out  1  core stopped
- illegal  out  1  halt was caused by an unknown opcode

## Operation
States and encodings:
- FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Encodings 6 and 7 go to HALT with illegal = 1.

Opcode classes, latched into an internal class register on the DECODE cycle only:
- LOAD 0000011, STORE 0100011, OP 0110011, OPIMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, SYSTEM 1110011.
- Any other opcode is ILLEGAL.
- opcode is ignored outside DECODE.

FETCH:
- imem_req = 1.
- When imem_ready = 1: ir_we = 1 and go to DECODE.
- Otherwise stay, with imem_req still high.

DECODE:
- SYSTEM → HALT.
- ILLEGAL → HALT and set illegal.
- Anything else → EXEC.
- No strobes.

EXEC:
- alu_src = 1 for LOAD, STORE, OPIMM, LUI, AUIPC, JALR; 0 otherwise.
- BRANCH: pc_we = 1, pc_sel = branch_taken ? 1 : 0, instret++, go to FETCH.
- LOAD or STORE → MEM.
- Everything else → WB.

MEM:
- dmem_req = 1, dmem_we = (class == STORE), alu_src = 1.
- Wait for dmem_ready.
- On ready, STORE: pc_we = 1, pc_sel = 0, instret++, go to FETCH.
- On ready, LOAD: go to WB.

WB (every output is for this cycle only):
- rf_we = 1.
- wb_sel = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
- pc_we = 1.
- pc_sel = 1 for JAL, 2 for JALR, 0 otherwise.
- instret++, go to FETCH.

HALT:
- All strobes 0, halted = 1.
- Stays in HALT until RST.

Output and counter rules:
- Strobes are combinational from state, class and the ready inputs.
- Every strobe not listed for a state is 0.
- instret wraps modulo 2^INSTRET_W.

## Timing
- Reset: RST high at a rising edge gives state = FETCH, instret = 0, halted = 0, illegal = 0, class = OP.
- While RST is high, every strobe output is forced to 0, including imem_req.
- RST overrides any in-progress state, including HALT and pending memory waits. A request abandoned by reset is simply dropped.
- Latency with zero memory wait: BRANCH 3 cycles; OP, OPIMM, LUI, AUIPC, JAL, JALR and STORE 4 cycles; LOAD 5 cycles.
- Each cycle imem_ready or dmem_ready is held low adds exactly one cycle.
- A ready input arriving outside its matching wait state is ignored.
- pc_we and instret++ fire on the same edge; exactly one of each per retired instruction.
- rf_we is never high in the same cycle as dmem_req or ir_we.
- SYSTEM and ILLEGAL instructions do not retire: instret is unchanged and pc_we is never asserted.

## Test plan
- Reset, then ADD (opcode 0110011) with imem_ready and dmem_ready tied high → state sequence 0,1,2,4,0; rf_we and pc_we high only in cycle 4 with wb_sel = 0 and pc_sel = 0; instret = 1.
- LW with dmem_ready low for 3 MEM cycles → dmem_req high for 4 cycles with dmem_we = 0; then WB with wb_sel = 1; total 8 cycles; instret = 1.
- BEQ with branch_taken = 1, then BEQ with branch_taken = 0 → pc_sel = 1 then 0, each in its EXEC cycle; rf_we never high; 3 cycles each; instret = 2.
- JALR → EXEC has alu_src = 1; WB has wb_sel = 2 and pc_sel = 2. SW → MEM has dmem_we = 1 and pc_we on the ready cycle; no WB state.
- Opcode 0000000 at DECODE → HALT with halted = 1, illegal = 1, instret unchanged. Toggling imem_ready then leaves all strobes at 0. RST pulse → FETCH with illegal = 0.
- ECALL (1110011) → HALT with illegal = 0. RST asserted during a MEM wait → all strobes 0 that cycle; next state FETCH; instret = 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control sequencer for a multi-cycle RV32 core. Each instruction is walked
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over several clocks, and
// every datapath strobe is driven from here. The block handshakes with the
// instruction and data memories, counts retired instructions, and halts on
// ECALL/EBREAK (SYSTEM class) or an unknown opcode.
//
// Ports
//   CLK           clock, all state updates on the rising edge
//   RST           synchronous active-high reset
//   opcode        inst[6:0] from the instruction register (sampled in DECODE)
//   branch_taken  ALU compare result, used in EXEC for branches
//   imem_ready    instruction word valid this cycle
//   dmem_ready    data access complete this cycle
//   imem_req      fetch request, held until imem_ready
//   ir_we         instruction register load strobe
//   pc_we         PC update strobe (one per retired instruction)
//   pc_sel        next PC: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm
//   alu_src       ALU operand B: 0 = rs2, 1 = imm
//   rf_we         register-file write strobe
//   wb_sel        writeback source: 0 = ALU, 1 = load data, 2 = PC+4
//   dmem_req      data access request, held until dmem_ready
//   dmem_we       1 = store, qualifies dmem_req
//   state         current state encoding, for debug
//   instret       retired-instruction count, wraps modulo 2^INSTRET_W
//   halted        core stopped
//   illegal       the halt was caused by an unknown opcode
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 alu_src,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 illegal
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_LOAD,
    C_STORE,
    C_OP,
    C_OPIMM,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BRANCH,
    C_SYSTEM,
    C_ILLEGAL
  } cls_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_REL    = 2'd1;
  localparam logic [1:0] PC_RS1    = 2'd2;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] WB_LINK   = 2'd2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic cls_e decode_class(input logic [6:0] op);
    cls_e c;
    case (op)
      OPC_LOAD:   c = C_LOAD;
      OPC_STORE:  c = C_STORE;
      OPC_OP:     c = C_OP;
      OPC_OPIMM:  c = C_OPIMM;
      OPC_LUI:    c = C_LUI;
      OPC_AUIPC:  c = C_AUIPC;
      OPC_JAL:    c = C_JAL;
      OPC_JALR:   c = C_JALR;
      OPC_BRANCH: c = C_BRANCH;
      OPC_SYSTEM: c = C_SYSTEM;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // Classes whose second ALU operand is the immediate.
  function automatic logic uses_imm(input cls_e c);
    return (c == C_LOAD)  || (c == C_STORE) || (c == C_OPIMM) ||
           (c == C_LUI)   || (c == C_AUIPC) || (c == C_JALR);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  cls_e                   cls_q, cls_d;
  logic                   illegal_q, illegal_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the combinational block below uses blocking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      cls_q     <= C_OP;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_src   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // The class is captured only here; later states steer off cls_q.
        cls_d = decode_class(opcode);
        case (cls_d)
          C_SYSTEM:  state_d = S_HALT;
          C_ILLEGAL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default:   state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        alu_src = uses_imm(cls_q);
        if (cls_q == C_BRANCH) begin
          // Branches retire straight out of EXEC.
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_REL : PC_PLUS4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if ((cls_q == C_LOAD) || (cls_q == C_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        alu_src  = 1'b1;
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            // Stores have nothing to write back and retire on the ready cycle.
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel = WB_LOAD;
          C_JAL,
          C_JALR:  wb_sel = WB_LINK;
          default: wb_sel = WB_ALU;
        endcase
        case (cls_q)
          C_JAL:   pc_sel = PC_REL;
          C_JALR:  pc_sel = PC_RS1;
          default: pc_sel = PC_PLUS4;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        // Unused encodings are treated as a corrupted sequencer.
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase

    // Reset silences every strobe in the same cycle, dropping any request
    // that was in flight.
    if (RST) begin
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_PLUS4;
      alu_src  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = WB_ALU;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each task drives a short table of
// per-cycle inputs and compares the state and the full strobe vector against
// hand-computed values, then checks the retired count. The counter is built
// 3 bits wide so the run also crosses its wrap point.
//
// Strobe vector bit order (11 bits):
//   {imem_req, ir_we, pc_we, pc_sel[1:0], alu_src, rf_we, wb_sel[1:0],
//    dmem_req, dmem_we}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int IW = 3;

  logic          CLK;
  logic          RST;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req;
  logic          ir_we;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic          alu_src;
  logic          rf_we;
  logic [1:0]    wb_sel;
  logic          dmem_req;
  logic          dmem_we;
  logic [2:0]    state;
  logic [IW-1:0] instret;
  logic          halted;
  logic          illegal;

  multicycle_ctrl #(.INSTRET_W(IW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src      (alu_src),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .state        (state),
    .instret      (instret),
    .halted       (halted),
    .illegal      (illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [10:0] strb;
  assign strb = {imem_req, ir_we, pc_we, pc_sel, alu_src, rf_we, wb_sel, dmem_req, dmem_we};

  // Opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b0000000;

  // Expected strobe patterns
  localparam logic [10:0] SB_NONE   = 11'b0_0_0_00_0_0_00_0_0;
  localparam logic [10:0] SB_FWAIT  = 11'b1_0_0_00_0_0_00_0_0;
  localparam logic [10:0] SB_FETCH  = 11'b1_1_0_00_0_0_00_0_0;
  localparam logic [10:0] SB_EXIMM  = 11'b0_0_0_00_1_0_00_0_0;
  localparam logic [10:0] SB_WBALU  = 11'b0_0_1_00_0_1_00_0_0;
  localparam logic [10:0] SB_LDWAIT = 11'b0_0_0_00_1_0_00_1_0;
  localparam logic [10:0] SB_WBLD   = 11'b0_0_1_00_0_1_01_0_0;
  localparam logic [10:0] SB_BR_T   = 11'b0_0_1_01_0_0_00_0_0;
  localparam logic [10:0] SB_BR_NT  = 11'b0_0_1_00_0_0_00_0_0;
  localparam logic [10:0] SB_WBJALR = 11'b0_0_1_10_0_1_10_0_0;
  localparam logic [10:0] SB_WBJAL  = 11'b0_0_1_01_0_1_10_0_0;
  localparam logic [10:0] SB_STDONE = 11'b0_0_1_00_1_0_00_1_1;

  typedef struct packed {
    logic [6:0]  op;
    logic        ir;
    logic        dr;
    logic        bt;
    logic [2:0]  st;
    logic [10:0] sb;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic ir, input logic dr,
                              input logic bt, input logic [2:0] st, input logic [10:0] sb);
    vec_t v;
    v.op = op; v.ir = ir; v.dr = dr; v.bt = bt; v.st = st; v.sb = sb;
    return v;
  endfunction

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [IW-1:0] exp_cnt  = '0;

  task automatic apply(input vec_t v);
    opcode       = v.op;
    imem_ready   = v.ir;
    dmem_ready   = v.dr;
    branch_taken = v.bt;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1; opcode = OP_ADD; branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    next_cycle();
    n_checks++;
    if (strb !== SB_NONE) begin
      n_fails++; $display("FAIL reset_strobes: got %b expected %b", strb, SB_NONE);
    end
    n_checks++;
    if ({state, instret, halted, illegal} !== {3'd0, {IW{1'b0}}, 1'b0, 1'b0}) begin
      n_fails++; $display("FAIL reset_status: got state=%0d instret=%0d halted=%b illegal=%b expected 0/0/0/0", state, instret, halted, illegal);
    end
    RST = 1'b0;
    #1;
    n_checks++;
    if (strb !== SB_FETCH) begin
      n_fails++; $display("FAIL reset_release_fetch: got %b expected %b", strb, SB_FETCH);
    end
    exp_cnt = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_add();
    vec_t v [4];
    v[0] = mk(OP_ADD, 1, 1, 0, 3'd0, SB_FETCH);
    v[1] = mk(OP_ADD, 1, 1, 0, 3'd1, SB_NONE);
    v[2] = mk(OP_ADD, 1, 1, 0, 3'd2, SB_NONE);
    v[3] = mk(OP_ADD, 1, 1, 0, 3'd4, SB_WBALU);
    for (int i = 0; i < 4; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL add[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if ({state, instret} !== {3'd0, exp_cnt}) begin
      n_fails++; $display("FAIL add_retire: got state=%0d instret=%0d expected 0/%0d", state, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // dmem_ready is high during FETCH..EXEC to show it is ignored there.
  task automatic test_load_wait();
    vec_t v [8];
    v[0] = mk(OP_LW, 1, 1, 0, 3'd0, SB_FETCH);
    v[1] = mk(OP_LW, 1, 1, 0, 3'd1, SB_NONE);
    v[2] = mk(OP_LW, 1, 1, 0, 3'd2, SB_EXIMM);
    v[3] = mk(OP_LW, 1, 0, 0, 3'd3, SB_LDWAIT);
    v[4] = mk(OP_LW, 1, 0, 0, 3'd3, SB_LDWAIT);
    v[5] = mk(OP_LW, 1, 0, 0, 3'd3, SB_LDWAIT);
    v[6] = mk(OP_LW, 1, 1, 0, 3'd3, SB_LDWAIT);
    v[7] = mk(OP_LW, 1, 1, 0, 3'd4, SB_WBLD);
    for (int i = 0; i < 8; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL load_wait[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 1'b1;
    n_checks++;
    if ({state, instret} !== {3'd0, exp_cnt}) begin
      n_fails++; $display("FAIL load_retire: got state=%0d instret=%0d expected 0/%0d", state, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Taken branch (with one fetch wait), then not-taken branch.
  task automatic test_branch();
    vec_t v [7];
    v[0] = mk(OP_BEQ, 0, 1, 1, 3'd0, SB_FWAIT);
    v[1] = mk(OP_BEQ, 1, 0, 1, 3'd0, SB_FETCH);
    v[2] = mk(OP_BEQ, 1, 1, 0, 3'd1, SB_NONE);
    v[3] = mk(OP_BEQ, 1, 1, 1, 3'd2, SB_BR_T);
    v[4] = mk(OP_BEQ, 1, 1, 1, 3'd0, SB_FETCH);
    v[5] = mk(OP_BEQ, 1, 1, 1, 3'd1, SB_NONE);
    v[6] = mk(OP_BEQ, 1, 1, 0, 3'd2, SB_BR_NT);
    for (int i = 0; i < 7; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL branch[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 2'd2;
    n_checks++;
    if ({state, instret} !== {3'd0, exp_cnt}) begin
      n_fails++; $display("FAIL branch_retire: got state=%0d instret=%0d expected 0/%0d", state, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // JALR, SW, JAL back to back.
  task automatic test_jump_store();
    vec_t v [12];
    v[0]  = mk(OP_JALR, 1, 0, 0, 3'd0, SB_FETCH);
    v[1]  = mk(OP_JALR, 1, 0, 0, 3'd1, SB_NONE);
    v[2]  = mk(OP_JALR, 1, 0, 0, 3'd2, SB_EXIMM);
    v[3]  = mk(OP_JALR, 1, 0, 0, 3'd4, SB_WBJALR);
    v[4]  = mk(OP_SW,   1, 1, 0, 3'd0, SB_FETCH);
    v[5]  = mk(OP_SW,   1, 1, 0, 3'd1, SB_NONE);
    v[6]  = mk(OP_SW,   1, 1, 0, 3'd2, SB_EXIMM);
    v[7]  = mk(OP_SW,   1, 1, 0, 3'd3, SB_STDONE);
    v[8]  = mk(OP_JAL,  1, 0, 1, 3'd0, SB_FETCH);
    v[9]  = mk(OP_JAL,  1, 0, 1, 3'd1, SB_NONE);
    v[10] = mk(OP_JAL,  1, 0, 1, 3'd2, SB_NONE);
    v[11] = mk(OP_JAL,  1, 0, 1, 3'd4, SB_WBJAL);
    for (int i = 0; i < 12; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL jump_store[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 2'd3;
    n_checks++;
    if ({state, instret} !== {3'd0, exp_cnt}) begin
      n_fails++; $display("FAIL jump_store_retire: got state=%0d instret=%0d expected 0/%0d", state, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // ADDI, LUI, AUIPC back to back; the counter wraps past 7 here.
  task automatic test_back_to_back();
    vec_t v [12];
    v[0]  = mk(OP_ADDI,  1, 0, 0, 3'd0, SB_FETCH);
    v[1]  = mk(OP_ADDI,  1, 0, 0, 3'd1, SB_NONE);
    v[2]  = mk(OP_ADDI,  1, 0, 0, 3'd2, SB_EXIMM);
    v[3]  = mk(OP_ADDI,  1, 0, 0, 3'd4, SB_WBALU);
    v[4]  = mk(OP_LUI,   1, 0, 0, 3'd0, SB_FETCH);
    v[5]  = mk(OP_LUI,   1, 0, 0, 3'd1, SB_NONE);
    v[6]  = mk(OP_LUI,   1, 0, 0, 3'd2, SB_EXIMM);
    v[7]  = mk(OP_LUI,   1, 0, 0, 3'd4, SB_WBALU);
    v[8]  = mk(OP_AUIPC, 1, 0, 0, 3'd0, SB_FETCH);
    v[9]  = mk(OP_AUIPC, 1, 0, 0, 3'd1, SB_NONE);
    v[10] = mk(OP_AUIPC, 1, 0, 0, 3'd2, SB_EXIMM);
    v[11] = mk(OP_AUIPC, 1, 0, 0, 3'd4, SB_WBALU);
    for (int i = 0; i < 12; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL back_to_back[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    exp_cnt = exp_cnt + 2'd3;
    n_checks++;
    if ({state, instret} !== {3'd0, exp_cnt}) begin
      n_fails++; $display("FAIL back_to_back_retire: got state=%0d instret=%0d expected 0/%0d", state, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Unknown opcode halts with illegal set; HALT ignores both ready inputs;
  // a reset pulse brings the core back.
  task automatic test_illegal();
    vec_t v [5];
    v[0] = mk(OP_BAD, 1, 0, 0, 3'd0, SB_FETCH);
    v[1] = mk(OP_BAD, 1, 0, 0, 3'd1, SB_NONE);
    v[2] = mk(OP_BAD, 1, 1, 0, 3'd5, SB_NONE);
    v[3] = mk(OP_ADD, 0, 1, 1, 3'd5, SB_NONE);
    v[4] = mk(OP_ADD, 1, 0, 1, 3'd5, SB_NONE);
    for (int i = 0; i < 5; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL illegal[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    n_checks++;
    if ({halted, illegal, instret} !== {1'b1, 1'b1, exp_cnt}) begin
      n_fails++; $display("FAIL illegal_halt: got halted=%b illegal=%b instret=%0d expected 1/1/%0d", halted, illegal, instret, exp_cnt);
    end
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    exp_cnt = '0;
    #1;
    n_checks++;
    if ({state, halted, illegal, instret} !== {3'd0, 1'b0, 1'b0, exp_cnt}) begin
      n_fails++; $display("FAIL illegal_recover: got state=%0d halted=%b illegal=%b instret=%0d expected 0/0/0/0", state, halted, illegal, instret);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reset arriving while a load waits in MEM drops the request at once.
  task automatic test_reset_in_mem();
    vec_t v [4];
    v[0] = mk(OP_LW, 1, 0, 0, 3'd0, SB_FETCH);
    v[1] = mk(OP_LW, 1, 0, 0, 3'd1, SB_NONE);
    v[2] = mk(OP_LW, 1, 0, 0, 3'd2, SB_EXIMM);
    v[3] = mk(OP_LW, 1, 0, 0, 3'd3, SB_LDWAIT);
    for (int i = 0; i < 4; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL reset_in_mem[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({state, strb} !== {3'd3, SB_NONE}) begin
      n_fails++; $display("FAIL reset_in_mem_silence: got state=%0d strobes=%b expected state=3 strobes=%b", state, strb, SB_NONE);
    end
    next_cycle();
    exp_cnt = '0;
    n_checks++;
    if ({state, instret, strb} !== {3'd0, exp_cnt, SB_NONE}) begin
      n_fails++; $display("FAIL reset_in_mem_after: got state=%0d instret=%0d strobes=%b expected 0/0/%b", state, instret, strb, SB_NONE);
    end
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ecall();
    vec_t v [3];
    v[0] = mk(OP_ECALL, 1, 0, 0, 3'd0, SB_FETCH);
    v[1] = mk(OP_ECALL, 1, 0, 0, 3'd1, SB_NONE);
    v[2] = mk(OP_ECALL, 1, 1, 1, 3'd5, SB_NONE);
    for (int i = 0; i < 3; i++) begin
      apply(v[i]); #1;
      n_checks++;
      if ({state, strb} !== {v[i].st, v[i].sb}) begin
        n_fails++; $display("FAIL ecall[%0d]: got state=%0d strobes=%b expected state=%0d strobes=%b", i, state, strb, v[i].st, v[i].sb);
      end
      next_cycle();
    end
    n_checks++;
    if ({halted, illegal, instret} !== {1'b1, 1'b0, exp_cnt}) begin
      n_fails++; $display("FAIL ecall_halt: got halted=%b illegal=%b instret=%0d expected 1/0/%0d", halted, illegal, instret, exp_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    RST = 1'b1; opcode = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jump_store();
    test_back_to_back();
    test_illegal();
    test_add();
    test_reset_in_mem();
    test_ecall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
